// File: rtl/bka_pkg.sv
// ----------------------------------------------------------------------------
// bka_pkg
// Types and helpers shared by the Brent-Kung adder and its black cell.
//   BKA_WIDTH  : operand width (fixed at 4)
//   pg_t       : (generate, propagate) pair for a bit or a group of bits
//   black_cell : prefix operator (G,P) o (G',P') = (G | P&G', P&P')
// ----------------------------------------------------------------------------
package bka_pkg;

  localparam int BKA_WIDTH = 4;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  // hi covers the more significant span, lo the span directly below it.
  function automatic pg_t black_cell(pg_t hi, pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/brent_kung_adder_if.sv
// ----------------------------------------------------------------------------
// brent_kung_adder_if
// Bit-level operand and result bundle for brent_kung_adder.
//   A_1..A_4, B_1..B_4 : operands, index 1 = LSB
//   C_0                : carry-in
//   S_1..S_4           : sum, index 1 = LSB
//   C_out              : carry-out (result bit 5)
// Modports:
//   master : the side that supplies operands and consumes the result
//   slave  : the adder itself
// ----------------------------------------------------------------------------
interface brent_kung_adder_if;

  logic A_1, A_2, A_3, A_4;
  logic B_1, B_2, B_3, B_4;
  logic C_0;
  logic S_1, S_2, S_3, S_4;
  logic C_out;

  modport master (
    output A_1, A_2, A_3, A_4,
    output B_1, B_2, B_3, B_4,
    output C_0,
    input  S_1, S_2, S_3, S_4,
    input  C_out
  );

  modport slave (
    input  A_1, A_2, A_3, A_4,
    input  B_1, B_2, B_3, B_4,
    input  C_0,
    output S_1, S_2, S_3, S_4,
    output C_out
  );

endinterface

// File: rtl/bk_black_cell.sv
// ----------------------------------------------------------------------------
// bk_black_cell
// One node of the prefix tree: combines a high (gh, ph) span with the
// adjacent low (gl, pl) span into the group (g, p) covering both.
//   gh, ph : generate/propagate of the more significant span
//   gl, pl : generate/propagate of the less significant span
//   g, p   : group generate/propagate
// ----------------------------------------------------------------------------
module bk_black_cell
  import bka_pkg::*;
(
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);

  pg_t hi;
  pg_t lo;
  pg_t grp;

  assign hi  = '{g: gh, p: ph};
  assign lo  = '{g: gl, p: pl};
  assign grp = black_cell(hi, lo);

  assign g = grp.g;
  assign p = grp.p;

endmodule

// File: rtl/brent_kung_adder.sv
// ----------------------------------------------------------------------------
// brent_kung_adder
// 4-bit Brent-Kung parallel-prefix adder with carry-in and carry-out:
// {C_out, S_4..S_1} = A + B + C_0, unsigned and exact.
//
// Ports:
//   clk : clock, used only by the optional output register
//   rst : asynchronous active-high reset of the optional output register
//   bus : brent_kung_adder_if.slave (operands, carry-in, sum, carry-out)
//
// Build option:
//   BKA_OUTPUT_REG_EN defined   : all five outputs are flopped (1-cycle
//                                 latency, cleared immediately by rst)
//   BKA_OUTPUT_REG_EN undefined : outputs are purely combinational and
//                                 clk/rst have no effect
// ----------------------------------------------------------------------------
module brent_kung_adder
  import bka_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  brent_kung_adder_if.slave       bus
);

  logic [BKA_WIDTH-1:0] a;
  logic [BKA_WIDTH-1:0] b;
  logic [BKA_WIDTH-1:0] g;
  logic [BKA_WIDTH-1:0] p;
  logic [BKA_WIDTH:0]   c;
  logic [BKA_WIDTH-1:0] sum;
  logic [BKA_WIDTH:0]   result_d;
  logic [BKA_WIDTH:0]   result;

  // Group (G,P) spans; names give the covered bit range, 1 = LSB.
  logic g21, p21;
  logic g43, p43;
  logic g41, p41;
  logic g31, p31;

  assign a = {bus.A_4, bus.A_3, bus.A_2, bus.A_1};
  assign b = {bus.B_4, bus.B_3, bus.B_2, bus.B_1};

  // Bit-level generate / propagate.
  assign g = a & b;
  assign p = a ^ b;

  // Up-sweep: pairs, then the full span.
  bk_black_cell u_up_21 (.gh(g[1]), .ph(p[1]), .gl(g[0]), .pl(p[0]), .g(g21), .p(p21));
  bk_black_cell u_up_43 (.gh(g[3]), .ph(p[3]), .gl(g[2]), .pl(p[2]), .g(g43), .p(p43));
  bk_black_cell u_up_41 (.gh(g43),  .ph(p43),  .gl(g21),  .pl(p21),  .g(g41), .p(p41));

  // Down-sweep: fills in the odd position left uncovered by the up-sweep.
  bk_black_cell u_dn_31 (.gh(g[2]), .ph(p[2]), .gl(g21),  .pl(p21),  .g(g31), .p(p31));

  // Carry merge with C_0. Each carry folds C_0 into the group span ending
  // at that bit; e.g. G[4:1] | P[4:1]&C_0 expands to G[4:3] | P[4:3]&c2,
  // and G[3:1] | P[3:1]&C_0 expands to g3 | p3&c2.
  assign c[0] = bus.C_0;
  assign c[1] = g[0] | (p[0] & bus.C_0);
  assign c[2] = g21  | (p21  & bus.C_0);
  assign c[3] = g31  | (p31  & bus.C_0);
  assign c[4] = g41  | (p41  & bus.C_0);

  assign sum      = p ^ c[BKA_WIDTH-1:0];
  assign result_d = {c[BKA_WIDTH], sum};

`ifdef BKA_OUTPUT_REG_EN
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, and the reset branch sits in the sensitivity
  // list so clearing does not wait for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else begin
      result <= result_d;
    end
  end
`else
  // clk and rst are kept on the port list so both builds share one
  // interface; this sink only marks them as intentionally unused.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  assign result = result_d;
`endif

  assign bus.S_1   = result[0];
  assign bus.S_2   = result[1];
  assign bus.S_3   = result[2];
  assign bus.S_4   = result[3];
  assign bus.C_out = result[4];

endmodule

// File: tb/tb_brent_kung_adder.sv
// ----------------------------------------------------------------------------
// tb_brent_kung_adder
// Self-checking bench for brent_kung_adder, valid for both the
// combinational build and the BKA_OUTPUT_REG_EN registered build.
// The reference is plain unsigned arithmetic A + B + C_0.
// ----------------------------------------------------------------------------
module tb_brent_kung_adder;

  logic clk;
  logic rst;
  logic [3:0] a_v;
  logic [3:0] b_v;
  logic       c_v;
  logic       cmp_en;
  logic [4:0] exp_q;
  int         total;
  int         bad;

  brent_kung_adder_if bus ();

  brent_kung_adder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.A_1 = a_v[0];
  assign bus.A_2 = a_v[1];
  assign bus.A_3 = a_v[2];
  assign bus.A_4 = a_v[3];
  assign bus.B_1 = b_v[0];
  assign bus.B_2 = b_v[1];
  assign bus.B_3 = b_v[2];
  assign bus.B_4 = b_v[3];
  assign bus.C_0 = c_v;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [4:0] model(logic [3:0] a, logic [3:0] b, logic c);
    return 5'(a) + 5'(b) + 5'(c);
  endfunction

  function automatic logic [4:0] dut_result();
    return {bus.C_out, bus.S_4, bus.S_3, bus.S_2, bus.S_1};
  endfunction

  task automatic check(string name, logic [4:0] act, logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b required %b (a=%0d b=%0d c=%0d t=%0t)",
               name, act, exp, a_v, b_v, c_v, $time);
    end
  endtask

  // Registered-build reference: what the output flops must hold after
  // each rising edge.
  always @(posedge clk) begin
    if (rst) exp_q <= 5'd0;
    else     exp_q <= model(a_v, b_v, c_v);
  end

  // Continuous compare on every falling edge while enabled.
  always @(negedge clk) begin
    if (cmp_en) begin
`ifdef BKA_OUTPUT_REG_EN
      check("stream", dut_result(), exp_q);
`else
      check("stream", dut_result(), model(a_v, b_v, c_v));
`endif
    end
  end

  task automatic apply(logic [3:0] a, logic [3:0] b, logic c);
    @(posedge clk);
    #1;
    a_v = a;
    b_v = b;
    c_v = c;
  endtask

  // Applies a vector and checks a hand-computed literal once it is visible.
  task automatic directed(string name, logic [3:0] a, logic [3:0] b, logic c,
                          logic [4:0] lit);
    apply(a, b, c);
`ifdef BKA_OUTPUT_REG_EN
    @(posedge clk);
`endif
    #1;
    check(name, dut_result(), lit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total  = 0;
    bad    = 0;
    cmp_en = 1'b0;
    rst    = 1'b1;
    a_v    = 4'd11;
    b_v    = 4'd6;
    c_v    = 1'b0;

    // Reset state (t=12, mid-cycle, rst still high).
    #12;
`ifdef BKA_OUTPUT_REG_EN
    check("reset_state", dut_result(), 5'd0);
`else
    check("reset_state", dut_result(), 5'd17);
`endif
    #1;
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Hand-computed vectors that pin the reference.
    directed("3+2+0",   4'd3,  4'd2,  1'b0, 5'b0_0101);
    directed("11+6+0",  4'd11, 4'd6,  1'b0, 5'b1_0001);
    directed("15+0+1",  4'd15, 4'd0,  1'b1, 5'b1_0000);
    directed("15+15+1", 4'd15, 4'd15, 1'b1, 5'b1_1111);
    directed("0+0+0",   4'd0,  4'd0,  1'b0, 5'b0_0000);
    directed("8+8+0",   4'd8,  4'd8,  1'b0, 5'b1_0000);

    // Exhaustive sweep; the compare process checks each cycle.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          apply(4'(ia), 4'(ib), 1'(ic));
        end
      end
    end
    @(posedge clk);
    @(negedge clk);

    // Asynchronous reset and first capture after release.
    cmp_en = 1'b0;
    apply(4'd11, 4'd6, 1'b0);
    @(posedge clk);
    #1;
    check("pre_rst", dut_result(), 5'd17);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
`ifdef BKA_OUTPUT_REG_EN
    check("rst_async", dut_result(), 5'd0);
`else
    check("rst_async", dut_result(), 5'd17);
`endif
    @(posedge clk);
    #1;
`ifdef BKA_OUTPUT_REG_EN
    check("rst_hold", dut_result(), 5'd0);
`else
    check("rst_hold", dut_result(), 5'd17);
`endif
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
`ifdef BKA_OUTPUT_REG_EN
    check("rst_release", dut_result(), 5'd0);
`else
    check("rst_release", dut_result(), 5'd17);
`endif
    @(posedge clk);
    #1;
    check("first_capture", dut_result(), 5'd17);

    // Mid-cycle input change.
    @(negedge clk);
    #1;
    a_v = 4'd3;
    b_v = 4'd2;
    c_v = 1'b0;
    #1;
`ifdef BKA_OUTPUT_REG_EN
    check("midcycle_before_edge", dut_result(), 5'd17);
`else
    check("midcycle_before_edge", dut_result(), 5'd5);
`endif
    @(posedge clk);
    #1;
    check("midcycle_after_edge", dut_result(), 5'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
